// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundle between the stopwatch counter/board pins and the scan driver.
//   d0..d3      BCD digits (d0 = tenths, rightmost .. d3 = minutes, leftmost)
//   blank_lz    leading-zero blanking enable for positions 3/2
//   brightness  on-time level, 0 = 1/8 duty .. 7 = full duty
//   an          anode enables, active-low, an[0] = rightmost digit
//   seg         segments, active-low, seg[0] = a .. seg[6] = g
//   dp          decimal point, active-low
//   frame_tick  one-cycle pulse when position 0 of a new frame is shown
// master: the side that supplies digits and observes the pins.
// slave : the scan driver itself.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic       blank_lz;
  logic [2:0] brightness;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output d0, d1, d2, d3, blank_lz, brightness,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  d0, d1, d2, d3, blank_lz, brightness,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed four-digit seven-segment driver for the stopwatch display.
// Each digit position owns a slot of REFRESH_DIV cycles; four slots form a
// frame. Digits and the blanking enable are sampled once per frame so a
// counter carry can never tear the display; brightness is sampled once per
// slot and sets how long the anode stays on within that slot.
//   clock      system clock
//   reset      asynchronous, active-high
//   disp       seg7_scan_driver_if.slave (digits in, display pins out)
// REFRESH_DIV must be a multiple of 8 and at least 16.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clock,
  input  logic                reset,
  seg7_scan_driver_if.slave   disp
);

  localparam int             CW    = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  LAST  = (CW)'(REFRESH_DIV - 1);
  localparam logic [CW:0]    SLICE = (CW+1)'(REFRESH_DIV / 8);

  logic [CW-1:0]   div_cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] sh_d;
  logic            sh_blz;
  logic [2:0]      bri_q;

  logic            slot_start;
  logic            capture;
  logic [3:0][3:0] cur_d;
  logic            cur_blz;
  logic [2:0]      cur_bri;
  logic [CW:0]     on_limit;
  logic            blank3;
  logic            blank2;
  logic            pos_blank;
  logic [3:0]      an_n;
  logic [6:0]      seg_n;
  logic            dp_n;

  // Segment patterns g..a, 0 = lit; non-BCD codes show nothing.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign slot_start = (div_cnt == '0);
  assign capture    = slot_start && (idx == 2'd0);

  // In the cycle a sample is taken the shadows still hold the old frame, so
  // the live inputs are used directly; this also makes the very first slot
  // after reset show fresh data instead of the cleared shadows.
  assign cur_d    = capture    ? {disp.d3, disp.d2, disp.d1, disp.d0} : sh_d;
  assign cur_blz  = capture    ? disp.blank_lz   : sh_blz;
  assign cur_bri  = slot_start ? disp.brightness : bri_q;
  assign on_limit = ((CW+1)'(cur_bri) + (CW+1)'(1)) * SLICE;

  assign blank3    = cur_blz && (cur_d[3] == 4'd0);
  assign blank2    = blank3 && (cur_d[2] == 4'd0);
  assign pos_blank = ((idx == 2'd3) && blank3) || ((idx == 2'd2) && blank2);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    an_n  = 4'hF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    if (!pos_blank) begin
      seg_n = decode(cur_d[idx]);
      if ({1'b0, div_cnt} < on_limit) an_n[idx] = 1'b0;
      // Points separate minutes.seconds and seconds.tenths.
      if ((idx == 2'd1) || (idx == 2'd3)) dp_n = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt         <= '0;
      idx             <= 2'd0;
      // NOTE: the shadow digits are reset too; they are a handful of flops,
      // not a memory, and a defined value keeps the first frame deterministic.
      sh_d            <= '0;
      sh_blz          <= 1'b0;
      bri_q           <= 3'd0;
      disp.an         <= 4'hF;
      disp.seg        <= 7'h7F;
      disp.dp         <= 1'b1;
      disp.frame_tick <= 1'b0;
    end else begin
      if (div_cnt == LAST) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + (CW)'(1);
      end
      if (slot_start) bri_q <= disp.brightness;
      if (capture) begin
        sh_d   <= {disp.d3, disp.d2, disp.d1, disp.d0};
        sh_blz <= disp.blank_lz;
      end
      disp.an         <= an_n;
      disp.seg        <= seg_n;
      disp.dp         <= dp_n;
      disp.frame_tick <= capture;
    end
  end

endmodule
